// File: rtl/prog_loader_if.sv
// rtl/prog_loader_if.sv - byte-stream intake and memory write port of the program loader
interface prog_loader_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 5
);
  logic                  in_valid;
  logic [DATA_WIDTH-1:0] in_data;
  logic                  in_ready;
  logic                  mem_wr_en;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wr_data;

  modport master (
    output in_valid, in_data,
    input  in_ready, mem_wr_en, mem_addr, mem_wr_data
  );

  modport slave (
    input  in_valid, in_data,
    output in_ready, mem_wr_en, mem_addr, mem_wr_data
  );
endinterface

// File: rtl/prog_loader.sv
// rtl/prog_loader.sv - framed program loader, CPU reset sequencer and run monitor
// Optional RUN watchdog enabled by defining PROG_LOADER_TIMEOUT_EN.
module prog_loader #(
  parameter int DATA_WIDTH     = 8,
  parameter int ADDR_WIDTH     = 5,
  parameter int RST_HOLD       = 2,
  parameter int TIMEOUT_CYCLES = 1200
) (
  input  logic        clk_,
  input  logic        rst,
  input  logic        start,
  prog_loader_if.slave bus,
  output logic        cpu_rst_n,
  input  logic        halt,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [1:0]  err_code,
  output logic [15:0] run_cycles
);
  localparam int CAP = 1 << ADDR_WIDTH;

  typedef enum logic [2:0] {
    S_IDLE, S_LEN, S_LOAD, S_CSUM, S_HOLD, S_RUN, S_HALTED, S_ERROR
  } state_t;

  state_t state_q, state_d;

  logic [DATA_WIDTH-1:0] len_q;
  logic [DATA_WIDTH-1:0] sum_q;
  logic [ADDR_WIDTH:0]   cnt_q;
  logic [7:0]            hold_cnt_q;

  logic accept, restart, len_bad, last_byte, timeout_hit;
  logic in_ready_d, busy_d, done_d, error_d, cpu_rst_n_d, wr_d;
  logic [1:0] err_code_d;

  assign accept    = bus.in_valid && bus.in_ready;
  assign restart   = start && (state_q == S_IDLE || state_q == S_HALTED || state_q == S_ERROR);
  assign len_bad   = (bus.in_data == '0) || (int'(bus.in_data) > CAP);
  assign last_byte = (int'(cnt_q) + 1 == int'(len_q));

`ifdef PROG_LOADER_TIMEOUT_EN
  assign timeout_hit = (run_cycles == 16'(TIMEOUT_CYCLES - 1));
`else
  assign timeout_hit = 1'b0;
`endif

  always_ff @(posedge clk_ or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (start) state_d = S_LEN;
      S_LEN:    if (accept) state_d = len_bad ? S_ERROR : S_LOAD;
      S_LOAD:   if (accept && last_byte) state_d = S_CSUM;
      S_CSUM:   if (accept) state_d = (bus.in_data == sum_q) ? S_HOLD : S_ERROR;
      S_HOLD:   if (hold_cnt_q == 8'(RST_HOLD - 1)) state_d = S_RUN;
      S_RUN: begin
        if (halt)             state_d = S_HALTED;
        else if (timeout_hit) state_d = S_ERROR;
      end
      S_HALTED: if (start) state_d = S_LEN;
      S_ERROR:  if (start) state_d = S_LEN;
      default:  state_d = S_IDLE;
    endcase
  end

  // Status outputs are registered copies of what the next state implies.
  always_comb begin
    in_ready_d  = (state_d == S_LEN) || (state_d == S_LOAD) || (state_d == S_CSUM);
    busy_d      = in_ready_d || (state_d == S_HOLD) || (state_d == S_RUN);
    done_d      = (state_d == S_HALTED);
    error_d     = (state_d == S_ERROR);
    cpu_rst_n_d = (state_d == S_RUN) || (state_d == S_HALTED);
    wr_d        = (state_q == S_LOAD) && accept;
    err_code_d  = err_code;
    if (restart) err_code_d = 2'd0;
    if (state_d == S_ERROR && state_q != S_ERROR) begin
      case (state_q)
        S_LEN:   err_code_d = 2'd1;
        S_CSUM:  err_code_d = 2'd2;
        default: err_code_d = 2'd3;
      endcase
    end
  end

  always_ff @(posedge clk_ or posedge rst) begin
    if (rst) begin
      bus.in_ready    <= 1'b0;
      bus.mem_wr_en   <= 1'b0;
      bus.mem_addr    <= '0;
      bus.mem_wr_data <= '0;
      cpu_rst_n       <= 1'b0;
      busy            <= 1'b0;
      done            <= 1'b0;
      error           <= 1'b0;
      err_code        <= 2'd0;
      run_cycles      <= 16'd0;
      len_q           <= '0;
      sum_q           <= '0;
      cnt_q           <= '0;
      hold_cnt_q      <= 8'd0;
    end else begin
      bus.in_ready  <= in_ready_d;
      bus.mem_wr_en <= wr_d;
      cpu_rst_n     <= cpu_rst_n_d;
      busy          <= busy_d;
      done          <= done_d;
      error         <= error_d;
      err_code      <= err_code_d;
      if (wr_d) begin
        bus.mem_addr    <= cnt_q[ADDR_WIDTH-1:0];
        bus.mem_wr_data <= bus.in_data;
        cnt_q           <= cnt_q + (ADDR_WIDTH + 1)'(1);
        sum_q           <= sum_q + bus.in_data;
      end
      if (state_q == S_LEN && accept) len_q <= bus.in_data;
      hold_cnt_q <= (state_q == S_HOLD) ? hold_cnt_q + 8'd1 : 8'd0;
      if (state_q == S_RUN && run_cycles != 16'hFFFF) run_cycles <= run_cycles + 16'd1;
      if (restart) begin
        cnt_q      <= '0;
        sum_q      <= '0;
        run_cycles <= 16'd0;
      end
    end
  end
endmodule

// File: tb/tb_prog_loader.sv
// tb/tb_prog_loader.sv - directed bench for prog_loader
module tb_prog_loader;
  logic        clk_ = 1'b0;
  logic        rst;
  logic        start;
  logic        halt;
  logic        cpu_rst_n, busy, done, error;
  logic [1:0]  err_code;
  logic [15:0] run_cycles;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  int wr_addr[$];
  int wr_data[$];
  int wr_cyc[$];

  prog_loader_if #(.DATA_WIDTH(8), .ADDR_WIDTH(5)) bus ();

  prog_loader #(
    .DATA_WIDTH(8), .ADDR_WIDTH(5), .RST_HOLD(2), .TIMEOUT_CYCLES(100)
  ) dut (
    .clk_(clk_), .rst(rst), .start(start), .bus(bus.slave),
    .cpu_rst_n(cpu_rst_n), .halt(halt), .busy(busy), .done(done),
    .error(error), .err_code(err_code), .run_cycles(run_cycles)
  );

  always #5 clk_ = ~clk_;

  always @(posedge clk_) cyc <= cyc + 1;

  always @(negedge clk_) begin
    if (bus.mem_wr_en === 1'b1) begin
      wr_addr.push_back(int'(bus.mem_addr));
      wr_data.push_back(int'(bus.mem_wr_data));
      wr_cyc.push_back(cyc);
    end
  end

  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk_);
      #1;
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step(1);
    start = 1'b0;
  endtask

  task automatic send(input logic [7:0] b);
    bit ok;
    ok = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_data  = b;
    for (int i = 0; i < 50 && !ok; i++) begin
      if (bus.in_ready === 1'b1) ok = 1'b1;
      step(1);
    end
    bus.in_valid = 1'b0;
    if (!ok) chk("send_timeout", 0, 1);
  endtask

  task automatic clear_writes();
    wr_addr.delete();
    wr_data.delete();
    wr_cyc.delete();
  endtask

  initial begin
    logic [7:0] sum;
    int addr_ok;

    rst = 1'b1; start = 1'b0; halt = 1'b0;
    bus.in_valid = 1'b0; bus.in_data = 8'h00;
    step(3);
    rst = 1'b0;
    step(1);
    chk("rst_in_ready", int'(bus.in_ready), 0);
    chk("rst_wr_en",    int'(bus.mem_wr_en), 0);
    chk("rst_addr",     int'(bus.mem_addr), 0);
    chk("rst_cpu_rst_n", int'(cpu_rst_n), 0);
    chk("rst_busy_done_err", int'({busy, done, error}), 0);
    chk("rst_err_code", int'(err_code), 0);
    chk("rst_run_cycles", int'(run_cycles), 0);

    // Good frame, valid held high
    pulse_start();
    chk("len_in_ready", int'(bus.in_ready), 1);
    chk("len_busy", int'(busy), 1);
    clear_writes();
    send(8'h03); send(8'h11); send(8'h22); send(8'h33); send(8'h66);
    chk("good_wr_count", wr_addr.size(), 3);
    if (wr_addr.size() == 3) begin
      chk("good_w0", (wr_addr[0] << 8) | wr_data[0], 32'h0011);
      chk("good_w1", (wr_addr[1] << 8) | wr_data[1], 32'h0122);
      chk("good_w2", (wr_addr[2] << 8) | wr_data[2], 32'h0233);
      chk("good_w_consec", wr_cyc[2] - wr_cyc[0], 2);
    end
    chk("hold_cpu_rst_n_0", int'(cpu_rst_n), 0);
    step(1);
    chk("hold_cpu_rst_n_1", int'(cpu_rst_n), 0);
    step(1);
    chk("run_cpu_rst_n", int'(cpu_rst_n), 1);
    chk("run_busy_err", int'({busy, error}), 2);
    chk("run_cycles_entry", int'(run_cycles), 0);

    // Halt 50 cycles after RUN entry
    step(49);
    chk("run_cycles_49", int'(run_cycles), 49);
    halt = 1'b1;
    step(1);
    halt = 1'b0;
    chk("halt_done", int'(done), 1);
    chk("halt_run_cycles", int'(run_cycles), 50);
    chk("halt_cpu_rst_n", int'(cpu_rst_n), 1);
    chk("halt_busy", int'(busy), 0);
    step(3);
    chk("halted_run_cycles_hold", int'(run_cycles), 50);

    // Restart from HALTED, then a bad checksum with halt asserted (ignored)
    pulse_start();
    chk("restart_cpu_rst_n", int'(cpu_rst_n), 0);
    chk("restart_done", int'(done), 0);
    chk("restart_run_cycles", int'(run_cycles), 0);
    halt = 1'b1;
    clear_writes();
    send(8'h03); send(8'h11); send(8'h22); send(8'h33); send(8'h67);
    halt = 1'b0;
    chk("csum_err", int'(error), 1);
    chk("csum_err_code", int'(err_code), 2);
    chk("csum_in_ready", int'(bus.in_ready), 0);
    step(4);
    chk("csum_cpu_rst_n", int'(cpu_rst_n), 0);
    chk("csum_wr_count", wr_addr.size(), 3);

    // Bad lengths 00 and 21
    pulse_start();
    chk("err_restart_clear", int'({error, err_code}), 0);
    clear_writes();
    send(8'h00);
    chk("len0_err", int'({error, err_code}), 3'b101);
    chk("len0_in_ready", int'(bus.in_ready), 0);
    pulse_start();
    send(8'h21);
    chk("len21_err", int'({error, err_code}), 3'b101);
    chk("len21_in_ready", int'(bus.in_ready), 0);
    step(2);
    chk("badlen_wr_count", wr_addr.size(), 0);

    // Full 32-byte frame with in_valid toggling
    pulse_start();
    clear_writes();
    send(8'h20);
    sum = 8'h00;
    for (int i = 0; i < 32; i++) begin
      step(1);
      send(8'(i * 7 + 3));
      sum = sum + 8'(i * 7 + 3);
    end
    step(1);
    send(sum);
    chk("full_wr_count", wr_addr.size(), 32);
    addr_ok = 1;
    for (int i = 0; i < wr_addr.size(); i++)
      if (wr_addr[i] != i || wr_data[i] != ((i * 7 + 3) & 8'hFF)) addr_ok = 0;
    chk("full_wr_content", addr_ok, 1);
    step(2);
    chk("full_run_cpu_rst_n", int'(cpu_rst_n), 1);

    // start in RUN is ignored
    pulse_start();
    chk("run_start_ignored", int'({bus.in_ready, cpu_rst_n, busy}), 3'b011);
    chk("run_cycles_1", int'(run_cycles), 1);

`ifdef PROG_LOADER_TIMEOUT_EN
    step(99);
    chk("timeout_err_code", int'(err_code), 3);
    chk("timeout_err", int'(error), 1);
    chk("timeout_run_cycles", int'(run_cycles), 100);
    chk("timeout_cpu_rst_n", int'(cpu_rst_n), 0);
`else
    step(199);
    chk("no_timeout_busy", int'({busy, error, cpu_rst_n}), 3'b101);
    chk("no_timeout_run_cycles", int'(run_cycles), 200);
`endif

    // Reset out of the run, then reset in the middle of a load
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    step(1);
    pulse_start();
    send(8'h20);
    for (int i = 0; i < 10; i++) begin
      step(1);
      send(8'(i));
    end
    chk("mid_wr_en_before", int'(bus.mem_wr_en), 1);
    #2;
    rst = 1'b1;
    #1;
    chk("mid_rst_wr_en", int'(bus.mem_wr_en), 0);
    chk("mid_rst_cpu_rst_n", int'(cpu_rst_n), 0);
    chk("mid_rst_in_ready", int'(bus.in_ready), 0);
    chk("mid_rst_addr_busy", int'({bus.mem_addr, busy}), 0);
    step(1);
    rst = 1'b0;
    bus.in_valid = 1'b1;
    step(2);
    bus.in_valid = 1'b0;
    chk("post_rst_idle", int'({busy, bus.in_ready, error, done}), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/prog_loader.md
Name: prog_loader

Overview:
- Upstream boot stage for the 8-bit, 32-word CPU.
- Accepts a framed byte stream over a valid/ready handshake and writes it into the CPU's instruction/data memory through a write port.
- Holds the CPU in reset during the load, then releases it after a checksum check.
- Monitors the CPU `halt` output and reports done/error status plus a run-cycle count to the system.

Parameters:
- DATA_WIDTH, 8: stream byte and memory word width.
- ADDR_WIDTH, 5: memory address width; capacity is 2**ADDR_WIDTH words.
- RST_HOLD, 2: cycles the CPU reset is held after a successful check, before release.
- TIMEOUT_CYCLES, 1200: RUN watchdog limit. Only used with the optional feature.

Ports:
- clk_ input 1: clock. All logic is on the rising edge.
- rst input 1: asynchronous, active-high reset.
- start input 1: single-cycle pulse that begins a load.
- in_valid input 1: stream byte valid.
- in_data input DATA_WIDTH: stream byte.
- in_ready output 1: loader can accept a byte.
- mem_wr_en output 1: memory write strobe.
- mem_addr output ADDR_WIDTH: write address.
- mem_wr_data output DATA_WIDTH: write data.
- cpu_rst_n output 1: active-low CPU reset.
- halt input 1: CPU halt flag.
- busy output 1: loader is in LEN, LOAD, CSUM, HOLD or RUN.
- done output 1: CPU halted normally.
- error output 1: load or run failed.
- err_code output 2: error cause. 0 none, 1 bad length, 2 checksum mismatch, 3 timeout.
- run_cycles output 16: number of cycles spent in RUN.

Behaviour:
- Clock and reset: one clock, `clk_`. Reset `rst` is asynchronous and active-high.
- Reset values: state IDLE; in_ready 0; mem_wr_en 0; mem_addr 0; mem_wr_data 0; cpu_rst_n 0; busy 0; done 0; error 0; err_code 0; run_cycles 0.
- Registered outputs: every output is registered.
- Byte transfer: a byte transfers on a rising edge where in_valid && in_ready. in_ready is 1 only in LEN, LOAD and CSUM.
- Frame format, in order:
  - Length byte N.
  - N data bytes.
  - Checksum byte = (sum of the data bytes) mod 256.
- IDLE: on `start`, go to LEN. In the same edge, clear done, error, err_code, run_cycles, the address counter and the running sum.
- LEN, on an accepted byte:
  - If N == 0 or N > 2**ADDR_WIDTH: go to ERROR with err_code 1.
  - Otherwise latch N and go to LOAD.
- LOAD, on an accepted byte:
  - In the cycle after the accepting edge, mem_wr_en = 1 for exactly one cycle, with mem_addr = current count and mem_wr_data = the byte.
  - The address counter increments and the byte is added to the running sum.
  - After the Nth byte, go to CSUM.
  - Back-to-back accepts give back-to-back writes. Gaps in in_valid produce no writes.
- CSUM, on an accepted byte:
  - If the byte equals the running sum: go to HOLD.
  - Otherwise: go to ERROR with err_code 2.
- HOLD: cpu_rst_n stays 0 for exactly RST_HOLD cycles, then go to RUN. cpu_rst_n = 1 from the RUN-entry edge onward.
- RUN:
  - run_cycles increments every cycle and saturates at 16'hFFFF.
  - halt is sampled only in RUN. halt == 1 goes to HALTED.
- HALTED: done = 1 and cpu_rst_n stays 1, so the CPU PC stays observable.
- ERROR: error = 1 and cpu_rst_n = 0.
- start handling:
  - start in HALTED or ERROR re-enters LEN and drives cpu_rst_n = 0 on that edge.
  - start in any other non-IDLE state is ignored.
- Ignored inputs: halt outside RUN is ignored. in_valid while in_ready = 0 is ignored and the byte is not consumed.
- Reset mid-operation: rst at any time forces the reset values immediately. Memory words already written are not cleared.
- Width rule: the running sum is DATA_WIDTH bits and wraps modulo 2**DATA_WIDTH.

Optional Feature:
- Macro: PROG_LOADER_TIMEOUT_EN.
- Defined: in RUN, when run_cycles reaches TIMEOUT_CYCLES with halt still 0, go to ERROR with err_code 3. cpu_rst_n returns to 0 on that edge.
- Undefined: there is no watchdog. RUN persists until halt, and err_code 3 never occurs.

Test Plan:
- Good frame:
  - Stimulus: reset, start, then stream 03, 11, 22, 33, 66 with in_valid held high.
  - Required: writes (0,11), (1,22), (2,33) on consecutive cycles; cpu_rst_n rises 2 cycles after the checksum accept; busy = 1 and error = 0.
- Bad checksum:
  - Stimulus: 03, 11, 22, 33, 67.
  - Required: three writes only; error = 1, err_code = 2, cpu_rst_n stays 0.
- Bad length:
  - Stimulus: length 00, and separately length 21 hex.
  - Required: ERROR with err_code 1 on the next cycle; in_ready = 0; no writes.
- Backpressure and reset:
  - Stimulus: 32-byte frame with in_valid toggling every other cycle; then a second run with rst asserted after 10 data bytes.
  - Required: first run gives exactly 32 writes at addresses 0..31, then RUN. Second run returns immediately to reset values: IDLE, cpu_rst_n = 0, mem_wr_en = 0.
- Halt:
  - Stimulus: good frame, halt asserted 50 cycles after RUN entry.
  - Required: done = 1, run_cycles = 50, cpu_rst_n = 1, busy = 0; a later start restarts the load with cpu_rst_n = 0.
- Timeout:
  - Stimulus: TIMEOUT_CYCLES = 100, halt never asserted.
  - Required with PROG_LOADER_TIMEOUT_EN: err_code = 3 once run_cycles reaches 100. Without the macro: still in RUN at 200 cycles with run_cycles = 200.
